sr_ff_bank_ctrl: RTL

//  Sequences a bank of NUM_FF master-slave SR flip-flops for NUM_REQ requesters. Each request

---
 rtl/sr_ctrl_pkg.sv | 23 ++
 rtl/sr_ff_bank_ctrl_rr_arbiter.sv | 44 ++++
 rtl/sr_ff_bank_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared encodings for the SR flip-flop bank controller.
package sr_ctrl_pkg;

  // Request operation codes as carried on req_op.
  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } opKind;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    INIT,
    INIT_SETTLE,
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    RESP
  } ctrlState;

endpackage

// File: rtl/sr_ff_bank_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping, and
// moves the pointer past the winner when the grant is taken.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  logic          found;

  // First valid requester at or above the pointer wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + int'(i)) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        winner      = cand;
      end
    end
  end

  // Pointer moves to winner+1 (mod N) when the grant is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(winner) == N - 1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/sr_ff_bank_ctrl.sv
// Sequences set/clear/toggle/read requests onto a bank of SR flip-flops,
// verifying each write by readback with bounded retries.
module sr_ff_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_FF    = 8,
  parameter  int RETRY_MAX = 2,
  localparam int IDXW      = $clog2(NUM_FF),
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [IDXW*NUM_REQ-1:0] req_idx,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_q,
  output logic                    rsp_err,
  output logic                    init_done,
  output logic [NUM_FF-1:0]       ff_S,
  output logic [NUM_FF-1:0]       ff_R,
  input  logic [NUM_FF-1:0]       ff_Q
);

  localparam int RCW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  ctrlState          state;
  opKind             curOp;
  logic [IDXW-1:0]   curIdx;
  logic [IDW-1:0]    curId;
  logic              expQ;
  logic [RCW-1:0]    retryCnt;
  logic [NUM_FF-1:0] ffS, ffR;
  logic              rspValid, rspQ, rspErr, initDone;
  logic [IDW-1:0]    rspId;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     winner;
  logic               advance;
  opKind              winOp;
  logic [IDXW-1:0]    winIdx;
  logic               winInRange;
  logic               winExp;
  logic               curQ;

  function automatic logic [NUM_FF-1:0] bitAt(input logic [IDXW-1:0] i);
    logic [NUM_FF-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_arbiter #(.N(NUM_REQ)) arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .winner  (winner)
  );

  // Grant decode and winner's request fields; expected value resolved at grant.
  always_comb begin
    advance    = (state == IDLE) && initDone && (|req_valid);
    req_ready  = advance ? grant : '0;
    winOp      = opKind'(req_op[int'(winner)*2 +: 2]);
    winIdx     = req_idx[int'(winner)*IDXW +: IDXW];
    winInRange = int'(winIdx) < NUM_FF;
    curQ       = ff_Q[curIdx];
    case (winOp)
      OP_SET:    winExp = 1'b1;
      OP_TOGGLE: winExp = ~ff_Q[winIdx];
      default:   winExp = 1'b0;
    endcase
  end

  // Controller FSM with registered S/R drives and response.
  // rsp_valid is loaded on the edge entering RESP so the pulse aligns with RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      ffS      <= '0;
      ffR      <= '0;
      rspValid <= 1'b0;
      rspQ     <= 1'b0;
      rspErr   <= 1'b0;
      rspId    <= '0;
      initDone <= 1'b0;
      retryCnt <= '0;
      curOp    <= OP_READ;
      curIdx   <= '0;
      curId    <= '0;
      expQ     <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        INIT: begin
          ffS   <= '0;
          ffR   <= '1;
          state <= INIT_SETTLE;
        end
        INIT_SETTLE: begin
          ffR      <= '0;
          initDone <= 1'b1;
          state    <= IDLE;
        end
        IDLE: begin
          if (advance) begin
            curOp    <= winOp;
            curIdx   <= winIdx;
            curId    <= winner;
            retryCnt <= '0;
            if (!winInRange) begin
              rspErr   <= 1'b1;
              rspQ     <= 1'b0;
              rspId    <= winner;
              rspValid <= 1'b1;
              state    <= RESP;
            end else if (winOp == OP_READ) begin
              state <= CHECK;
            end else begin
              expQ  <= winExp;
              ffS   <= winExp ? bitAt(winIdx) : '0;
              ffR   <= winExp ? '0 : bitAt(winIdx);
              state <= DRIVE;
            end
          end
        end
        DRIVE: begin
          ffS   <= '0;
          ffR   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          state <= CHECK;
        end
        CHECK: begin
          rspQ <= curQ;
          if (curOp == OP_READ || curQ == expQ) begin
            rspErr   <= 1'b0;
            rspId    <= curId;
            rspValid <= 1'b1;
            state    <= RESP;
          end else if (int'(retryCnt) < RETRY_MAX) begin
            retryCnt <= retryCnt + 1'b1;
            ffS      <= expQ ? bitAt(curIdx) : '0;
            ffR      <= expQ ? '0 : bitAt(curIdx);
            state    <= DRIVE;
          end else begin
            rspErr   <= 1'b1;
            rspId    <= curId;
            rspValid <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          retryCnt <= '0;
          state    <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign ff_S      = ffS;
  assign ff_R      = ffR;
  assign rsp_valid = rspValid;
  assign rsp_id    = rspId;
  assign rsp_q     = rspQ;
  assign rsp_err   = rspErr;
  assign init_done = initDone;

endmodule
